// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding,
// word-alignment mask and an alignment helper.
package dmem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RESP  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_e;

    // Clears the byte-offset bits of a byte address.
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic is_aligned(input logic [31:0] a);
        return (a & ~WORD_ALIGN_MASK) == 32'h0;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Valid/ready data bus between the bridge (master) and memory (slave).
//   bus_valid/bus_we/bus_addr/bus_wdata : request, master -> slave
//   bus_ready                           : request accepted when valid&ready
//   bus_rvalid/bus_rdata                : read response
//   bus_err                             : error, qualifies ready (writes) or rvalid (reads)
interface dmem_bridge_if;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/dmem_timeout.sv
// Transaction watchdog: CW-bit counter, cleared at transaction start and
// advanced while the bridge waits on the bus.
//   clk, reset  : clock, synchronous active-high reset
//   clr_i       : restart count (entry to ADDR)
//   en_i        : waiting cycle (ADDR or RESP)
//   expired_o   : this waiting cycle is the last one allowed
module dmem_timeout #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            assign expired_o = en_i && (cnt_q == LAST);
        end
    endgenerate
endmodule

// File: rtl/dmem_bridge.sv
// Data-memory access stage: turns the single-cycle core's memory request
// into a variable-latency valid/ready bus transaction and stalls the core
// until it completes, errors or times out.
//   clk, reset          : clock, synchronous active-high reset
//   MemEn, MemWrite     : access request / store select
//   Addr, WData         : byte address, store data
//   RData               : last successfully loaded word
//   Stall               : core holds PC and register write
//   DataAbort           : one-cycle abort pulse (misaligned, bus error, timeout)
//   bus                 : valid/ready memory bus (master side)
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemEn,
    input  logic               MemWrite,
    input  logic [31:0]        Addr,
    input  logic [31:0]        WData,
    output logic [31:0]        RData,
    output logic               Stall,
    output logic               DataAbort,
    dmem_bridge_if.master      bus
);
    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        start;
    logic        waiting;
    logic        expired;

    assign waiting = (state_q == ADDR) || (state_q == RESP);

    dmem_timeout #(.TIMEOUT(TIMEOUT), .CW(CW)) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (start),
        .en_i      (waiting),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemEn) begin
                    if (is_aligned(Addr)) begin
                        addr_d  = Addr & WORD_ALIGN_MASK;
                        wdata_d = WData;
                        we_d    = MemWrite;
                        start   = 1'b1;
                        state_d = ADDR;
                    end else begin
                        state_d = ABORT;
                    end
                end
            end
            ADDR: begin
                // Acceptance is checked first so it beats a same-cycle timeout.
                if (bus.bus_ready)
                    state_d = bus.bus_err ? ABORT : (we_q ? DONE : RESP);
                else if (expired)
                    state_d = ABORT;
            end
            RESP: begin
                if (bus.bus_rvalid) begin
                    if (bus.bus_err) begin
                        state_d = ABORT;
                    end else begin
                        rdata_d = bus.bus_rdata;
                        state_d = DONE;
                    end
                end else if (expired) begin
                    state_d = ABORT;
                end
            end
            default: state_d = IDLE;   // DONE, ABORT: single-cycle retire
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall asserts combinationally in the request cycle so the core never
    // retires a memory instruction before the bridge has seen it.
    always_comb begin
        Stall         = ((state_q == IDLE) && MemEn) || waiting;
        DataAbort     = (state_q == ABORT);
        bus.bus_valid = (state_q == ADDR);
        bus.bus_we    = we_q;
        bus.bus_addr  = addr_q;
        bus.bus_wdata = wdata_q;
        RData         = rdata_q;
    end
endmodule
